// File: rtl/branch_pc_unit_if.sv
// Decode-side bundle between the branch decision logic / decode stage and branch_pc_unit.
// The unit attaches through the slave modport; the driving side uses master.
interface branch_pc_unit_if;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        Branch;
    logic        BLink;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] dec_pc;
    logic        redirect;
    logic        flush;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        ds_err;

    modport master (
        output stall, instr, instr_valid, Branch, BLink, jr_target,
        input  pc, dec_pc, redirect, flush, link_we, link_addr, link_data, ds_err
    );

    modport slave (
        input  stall, instr, instr_valid, Branch, BLink, jr_target,
        output pc, dec_pc, redirect, flush, link_we, link_addr, link_data, ds_err
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC owner: picks branch/jump targets, redirects fetch and issues link-register writes.
// Build option DELAY_SLOT_EN: defined = MIPS delay slot (flush tied 0); undefined = flush-on-take (ds_err tied 0).
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic            clk,
    input  logic            rst,
    branch_pc_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dec_pc_q, dec_pc_d;
    logic        redirect_q, redirect_d;
    logic        link_we_q, link_we_d;
    logic [4:0]  link_addr_q, link_addr_d;
    logic [31:0] link_data_q, link_data_d;
`ifdef DELAY_SLOT_EN
    logic        ds_err_q, ds_err_d;
`else
    logic        flush_q, flush_d;
`endif

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_jabs, is_jal, is_jreg, is_jalr;
    logic        take, link_req;
    logic [31:0] dec_pc_plus4, br_offset, target;

    assign opcode  = bus.instr[31:26];
    assign funct   = bus.instr[5:0];
    assign is_jabs = bus.instr_valid && (opcode == OP_J || opcode == OP_JAL);
    assign is_jal  = is_jabs && (opcode == OP_JAL);
    assign is_jreg = bus.instr_valid && (opcode == OP_SPECIAL) && (funct == FN_JR || funct == FN_JALR);
    assign is_jalr = is_jreg && (funct == FN_JALR);
    assign take    = is_jabs || is_jreg || (bus.instr_valid && bus.Branch);
    // BLink without a taken conditional branch is meaningless and is dropped.
    assign link_req = is_jal || is_jalr ||
                      (!is_jabs && !is_jreg && bus.instr_valid && bus.Branch && bus.BLink);

    assign dec_pc_plus4 = dec_pc_q + 32'd4;
    assign br_offset    = {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};

    always_comb begin
        if (is_jabs) begin
            target = {dec_pc_plus4[31:28], bus.instr[25:0], 2'b00};
        end else if (is_jreg) begin
            target = bus.jr_target;
        end else begin
            target = dec_pc_plus4 + br_offset;
        end
    end

    // NOTE: every _d gets a default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dec_pc_d    = dec_pc_q;
        redirect_d  = redirect_q;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        link_data_d = link_data_q;
`ifdef DELAY_SLOT_EN
        ds_err_d    = ds_err_q;
`else
        flush_d     = flush_q;
`endif
        if (!bus.stall) begin
            dec_pc_d   = pc_q;
            pc_d       = pc_q + 32'd4;
            redirect_d = 1'b0;
            state_d    = ST_RUN;
`ifndef DELAY_SLOT_EN
            flush_d    = 1'b0;
`endif
            if (take && state_q == ST_RUN) begin
                pc_d       = target;
                redirect_d = 1'b1;
`ifdef DELAY_SLOT_EN
                state_d    = ST_SLOT;
`else
                flush_d    = 1'b1;
`endif
                if (link_req) begin
                    link_we_d   = 1'b1;
                    link_addr_d = is_jalr ? bus.instr[15:11] : LINK_REG;
                    link_data_d = dec_pc_q + 32'd8;
                end
            end
`ifdef DELAY_SLOT_EN
            // A branch sitting in a delay slot is not honoured, only recorded.
            else if (take) begin
                ds_err_d = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            dec_pc_q    <= RESET_PC;
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= 5'd0;
            link_data_q <= 32'd0;
`ifdef DELAY_SLOT_EN
            ds_err_q    <= 1'b0;
`else
            flush_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dec_pc_q    <= dec_pc_d;
            redirect_q  <= redirect_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            link_data_q <= link_data_d;
`ifdef DELAY_SLOT_EN
            ds_err_q    <= ds_err_d;
`else
            flush_q     <= flush_d;
`endif
        end
    end

    assign bus.pc        = pc_q;
    assign bus.dec_pc    = dec_pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_addr = link_addr_q;
    assign bus.link_data = link_data_q;
`ifdef DELAY_SLOT_EN
    assign bus.ds_err    = ds_err_q;
    assign bus.flush     = 1'b0;
`else
    assign bus.ds_err    = 1'b0;
    assign bus.flush     = flush_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, hand sequences, then random
// stimulus against a behavioural model; adapts its expectations to the DELAY_SLOT_EN build.
module tb_branch_pc_unit;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam bit NDS = !DS;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] BEQ_M4 = 32'h1000_FFFC;
    localparam logic [31:0] BEQ_P4 = 32'h1000_0004;
    localparam logic [31:0] BGEZAL = 32'h0411_0010;
    localparam logic [31:0] JR_I   = 32'h0000_0008;
    localparam logic [31:0] JALR5  = 32'h0000_2809;
    localparam logic [31:0] J200   = 32'h0800_0080;
    localparam logic [31:0] JAL100 = 32'h0C00_0040;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    branch_pc_unit_if bus ();

    branch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .LINK_REG (5'd31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state.
    logic [31:0] m_pc, m_dec, m_ld;
    logic [4:0]  m_la;
    bit          m_red, m_fl, m_we, m_err, m_slot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [5:0]  op, fn;
        bit          jabs, jreg, want, lnk, was_slot;
        logic [31:0] tgt, old_pc;
        logic [4:0]  ldst;
        if (rst) begin
            m_pc = 32'h0; m_dec = 32'h0; m_ld = 32'h0; m_la = 5'd0;
            m_red = 0; m_fl = 0; m_we = 0; m_err = 0; m_slot = 0;
            return;
        end
        if (bus.stall) begin
            m_we = 0;
            return;
        end
        op   = bus.instr[31:26];
        fn   = bus.instr[5:0];
        jabs = bus.instr_valid && (op == 6'd2 || op == 6'd3);
        jreg = bus.instr_valid && op == 6'd0 && (fn == 6'd8 || fn == 6'd9);
        want = jabs || jreg || (bus.instr_valid && bus.Branch);
        if (jabs)
            tgt = ((m_dec + 32'd4) & 32'hF000_0000) | (32'(bus.instr[25:0]) << 2);
        else if (jreg)
            tgt = bus.jr_target;
        else
            tgt = m_dec + 32'd4 + 32'(int'($signed(bus.instr[15:0])) * 4);
        lnk  = (jabs && op == 6'd3) || (jreg && fn == 6'd9) ||
               (!jabs && !jreg && bus.instr_valid && bus.Branch && bus.BLink);
        ldst = (jreg && fn == 6'd9) ? bus.instr[15:11] : 5'd31;

        old_pc   = m_pc;
        was_slot = m_slot;
        m_slot = 0; m_red = 0; m_fl = 0; m_we = 0;
        if (want && !was_slot) begin
            m_pc  = tgt;
            m_red = 1;
            if (DS) m_slot = 1;
            else    m_fl = 1;
            if (lnk) begin
                m_we = 1;
                m_la = ldst;
                m_ld = m_dec + 32'd8;
            end
        end else begin
            m_pc = old_pc + 32'd4;
            if (want) m_err = 1;
        end
        m_dec = old_pc;
    endtask

    task automatic cmp_model();
        check("model pc",        bus.pc,        m_pc);
        check("model dec_pc",    bus.dec_pc,    m_dec);
        check("model redirect",  32'(bus.redirect),  32'(m_red));
        check("model flush",     32'(bus.flush),     32'(m_fl));
        check("model link_we",   32'(bus.link_we),   32'(m_we));
        check("model link_addr", 32'(bus.link_addr), 32'(m_la));
        check("model link_data", bus.link_data, m_ld);
        check("model ds_err",    32'(bus.ds_err),    32'(m_err));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare #1 later.
    task automatic apply(input bit r, input bit s, input bit v, input bit b, input bit l,
                         input logic [31:0] ins, input logic [31:0] jt);
        rst             = r;
        bus.stall       = s;
        bus.instr_valid = v;
        bus.Branch      = b;
        bus.BLink       = l;
        bus.instr       = ins;
        bus.jr_target   = jt;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        cmp_model();
    endtask

    typedef struct {
        bit          r, s, v, b, l;
        logic [31:0] ins, jt;
        logic [31:0] pc, dec;
        bit          red, fl, we, err;
        logic [4:0]  la;
        logic [31:0] ld;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit r, s, v, b, l, input logic [31:0] ins, jt, pc, dec,
                       input bit red, fl, we, err, input logic [4:0] la, input logic [31:0] ld);
        vec_t x;
        x.r = r; x.s = s; x.v = v; x.b = b; x.l = l; x.ins = ins; x.jt = jt;
        x.pc = pc; x.dec = dec; x.red = red; x.fl = fl; x.we = we; x.err = err;
        x.la = la; x.ld = ld;
        vt.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.instr_valid = 1'b0; bus.Branch = 1'b0; bus.BLink = 1'b0;
        bus.instr = 32'h0; bus.jr_target = 32'h0;

        //  r  s  v   b  l  instr   jr_tgt        pc            dec_pc        red fl   we err la  link_data
        add(1, 0, 1,  0, 0, NOP,    0,            32'h0,        32'h0,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h4,        32'h0,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h8,        32'h4,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'hC,        32'h8,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h10,       32'hC,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h14,       32'h10,       0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  1, 0, BEQ_M4, 0,            32'h4,        32'h14,       1, NDS, 0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h8,        32'h4,        0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, JR_I,   32'h1C,       32'h1C,       32'h8,        1, NDS, 0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h20,       32'h1C,       0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h24,       32'h20,       0, 0,   0, 0,  0,  32'h0);
        add(0, 0, 1,  1, 1, BGEZAL, 0,            32'h64,       32'h24,       1, NDS, 1, 0,  31, 32'h28);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h68,       32'h64,       0, 0,   0, 0,  31, 32'h28);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h6C,       32'h68,       0, 0,   0, 0,  31, 32'h28);
        add(0, 0, 1,  0, 0, JALR5,  32'h400,      32'h400,      32'h6C,       1, NDS, 1, 0,  5,  32'h70);
        add(0, 0, DS, 0, 0, J200,   0,            32'h404,      32'h400,      0, 0,   0, DS, 5,  32'h70);
        add(0, 0, 1,  0, 0, J200,   0,            32'h200,      32'h404,      1, NDS, 0, DS, 5,  32'h70);
        add(0, 0, 0,  1, 0, BEQ_M4, 0,            32'h204,      32'h200,      0, 0,   0, DS, 5,  32'h70);
        add(0, 0, 1,  0, 1, BGEZAL, 0,            32'h208,      32'h204,      0, 0,   0, DS, 5,  32'h70);
        add(0, 0, 1,  0, 0, JR_I,   32'h40,       32'h40,       32'h208,      1, NDS, 0, DS, 5,  32'h70);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h44,       32'h40,       0, 0,   0, DS, 5,  32'h70);
        add(0, 0, 1,  0, 0, JAL100, 0,            32'h100,      32'h44,       1, NDS, 1, DS, 31, 32'h48);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h104,      32'h100,      0, 0,   0, DS, 31, 32'h48);
        add(0, 0, 1,  0, 0, JR_I,   32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h104,    1, NDS, 0, DS, 31, 32'h48);
        add(0, 0, 1,  0, 0, NOP,    0,            32'hFFFF_FFFC, 32'hFFFF_FFF8, 0, 0, 0, DS, 31, 32'h48);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h0,        32'hFFFF_FFFC, 0, 0,  0, DS, 31, 32'h48);
        add(0, 0, 1,  1, 0, BEQ_P4, 0,            32'h10,       32'h0,        1, NDS, 0, DS, 31, 32'h48);
        add(0, 0, 1,  0, 0, NOP,    0,            32'h14,       32'h10,       0, 0,   0, DS, 31, 32'h48);

        foreach (vt[i]) begin
            apply(vt[i].r, vt[i].s, vt[i].v, vt[i].b, vt[i].l, vt[i].ins, vt[i].jt);
            check("vec pc",        bus.pc,               vt[i].pc);
            check("vec dec_pc",    bus.dec_pc,           vt[i].dec);
            check("vec redirect",  32'(bus.redirect),    32'(vt[i].red));
            check("vec flush",     32'(bus.flush),       32'(vt[i].fl));
            check("vec link_we",   32'(bus.link_we),     32'(vt[i].we));
            check("vec link_addr", 32'(bus.link_addr),   32'(vt[i].la));
            check("vec link_data", bus.link_data,        vt[i].ld);
            check("vec ds_err",    32'(bus.ds_err),      32'(vt[i].err));
        end

        // Taken branch-and-link held off by a 3-cycle stall, then honoured exactly once.
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 1, 1, BGEZAL, 0);
            check("stall pc",       bus.pc,              32'h14);
            check("stall dec_pc",   bus.dec_pc,          32'h10);
            check("stall link_we",  32'(bus.link_we),    32'd0);
            check("stall redirect", 32'(bus.redirect),   32'd0);
        end
        apply(0, 0, 1, 1, 1, BGEZAL, 0);
        check("unstall pc",        bus.pc,               32'h54);
        check("unstall redirect",  32'(bus.redirect),    32'd1);
        check("unstall link_we",   32'(bus.link_we),     32'd1);
        check("unstall link_data", bus.link_data,        32'h18);
        apply(0, 0, 1, 0, 0, NOP, 0);
        check("after redirect",    32'(bus.redirect),    32'd0);
        check("after link_we",     32'(bus.link_we),     32'd0);
        check("after pc",          bus.pc,               32'h58);

        // Redirect holds across a stall; then a J in the following slot.
        apply(0, 0, 1, 0, 0, JR_I, 32'h300);
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 1, 0, 0, J200, 0);
            check("hold redirect", 32'(bus.redirect), 32'd1);
            check("hold pc",       bus.pc,            32'h300);
        end
        apply(0, 0, 1, 0, 0, J200, 0);
        check("slot J pc",     bus.pc,            DS ? 32'h304 : 32'h200);
        check("slot J ds_err", 32'(bus.ds_err),   32'(DS));

        // Reset while a redirect is in flight (and under stall) wins; state is RUN afterwards.
        apply(0, 0, 1, 0, 0, JR_I, 32'h500);
        apply(1, 1, 1, 0, 0, J200, 0);
        check("rst pc",       bus.pc,            32'h0);
        check("rst dec_pc",   bus.dec_pc,        32'h0);
        check("rst redirect", 32'(bus.redirect), 32'd0);
        check("rst ds_err",   32'(bus.ds_err),   32'd0);
        apply(0, 0, 1, 0, 0, J200, 0);
        check("post-rst J pc",       bus.pc,            32'h200);
        check("post-rst J redirect", 32'(bus.redirect), 32'd1);

        // Random traffic against the model.
        apply(1, 0, 0, 0, 0, NOP, 0);
        for (int n = 0; n < 800; n++) begin
            int          k;
            logic [31:0] ins;
            bit          b, l;
            k = $urandom_range(0, 9);
            ins = $urandom();
            b = 0;
            l = 0;
            case (k)
                0: ins[31:26] = 6'h02;
                1: ins[31:26] = 6'h03;
                2: begin ins[31:26] = 6'h00; ins[5:0] = 6'h08; end
                3: begin ins[31:26] = 6'h00; ins[5:0] = 6'h09; end
                4, 5, 6: begin
                    ins[31:26] = (k == 4) ? 6'h01 : 6'h04;
                    b = ($urandom_range(0, 1) == 1);
                    l = ($urandom_range(0, 2) == 0);
                end
                default: ins[31:26] = 6'h08;
            endcase
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) != 0, b, l, ins, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
